// File: rtl/trace_pkg.sv
// Shared types, constants and the store-data masking helper for the retire
// trace buffer.
package trace_pkg;

  // Number of rd address bits that name an architectural register.
  localparam int REG_AW = 5;

  // Bit positions inside the one-hot store/load width vectors.
  localparam int MEM_WEN_B = 0;
  localparam int MEM_WEN_H = 1;
  localparam int MEM_WEN_W = 2;

  // One complete retire record as handed to the register-status writer.
  typedef struct packed {
    logic [31:0]       pc;
    logic [REG_AW-1:0] rd_addr;
    logic [31:0]       rd_wdata;
    logic [2:0]        mem_wen;
    logic [31:0]       mem_waddr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_raddr;
  } trace_rec_t;

  // Keep only the bytes a store actually writes; the narrowest width wins
  // when the core drives more than one width bit.
  function automatic logic [31:0] mask_store_data(input logic [2:0]  wen,
                                                  input logic [31:0] wdata);
    logic [31:0] res;
    res = '0;
    if (wen[MEM_WEN_B])      res = {24'd0, wdata[7:0]};
    else if (wen[MEM_WEN_H]) res = {16'd0, wdata[15:0]};
    else if (wen[MEM_WEN_W]) res = wdata;
    return res;
  endfunction

endpackage

// File: rtl/trace_pend_match.sv
// Oldest-first search for a pending entry waiting on a given register.
// The scan starts at the buffer head so the first hit is the oldest entry;
// an optional excluded slot lets a second port skip the first port's pick.
module trace_pend_match
  import trace_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                          en,
  input  logic [REG_AW-1:0]             addr,
  input  logic [DEPTH-1:0]              pend,
  input  logic [DEPTH-1:0][REG_AW-1:0]  rd_addrs,
  input  logic [PW-1:0]                 head,
  input  logic                          excl_en,
  input  logic [PW-1:0]                 excl_idx,
  output logic                          hit,
  output logic [PW-1:0]                 idx
);

  logic [PW-1:0] slot;

  // Walk slots in age order from the head and latch the first qualifying one.
  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    slot = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = head + PW'(i);
      if (!hit && en && pend[slot] && (rd_addrs[slot] == addr) &&
          !(excl_en && (slot == excl_idx))) begin
        hit = 1'b1;
        idx = slot;
      end
    end
  end

endmodule

// File: rtl/retire_trace_buf.sv
// Retire trace collector: keeps retired instructions in program order, holds
// records whose rd value arrives on a late writeback port, and releases only
// complete records to the downstream writer over valid/ready.
module retire_trace_buf
  import trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 7
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             ret_vld,
  output logic             ret_rdy,
  input  logic [31:0]      ret_pc,
  input  logic             ret_rd_en,
  input  logic [AW-1:0]    ret_rd_addr,
  input  logic [31:0]      ret_rd_wdata,
  input  logic             ret_rd_pend,
  input  logic [2:0]       ret_mem_ren,
  input  logic [31:0]      ret_mem_raddr,
  input  logic [2:0]       ret_mem_wen,
  input  logic [31:0]      ret_mem_waddr,
  input  logic [31:0]      ret_mem_wdata,
  input  logic             wrd_en1,
  input  logic [AW-1:0]    wrd_add1,
  input  logic [31:0]      wrd_data1,
  input  logic             wrd_en2,
  input  logic [AW-1:0]    wrd_add2,
  input  logic [31:0]      wrd_data2,
  output logic             out_vld,
  input  logic             out_rdy,
  output trace_rec_t       out_rec,
  output logic [31:0]      retired_cnt_o,
  output logic             ovf_o,
  output logic             orphan_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Storage and control state.
  trace_rec_t                  entries [DEPTH];
  logic [DEPTH-1:0]            pend;
  logic [PW-1:0]               rd_ptr;
  logic [PW-1:0]               wr_ptr;
  logic [CW-1:0]               count;

  // Derived per-cycle signals.
  logic                        rd_valid;
  logic                        qual;
  logic                        full;
  logic                        push;
  logic                        pop;
  trace_rec_t                  new_rec;
  logic                        new_pend;
  logic [DEPTH-1:0][REG_AW-1:0] rd_addrs;
  logic                        wb1_en;
  logic                        wb2_en;
  logic                        hit1;
  logic                        hit2;
  logic [PW-1:0]               idx1;
  logic [PW-1:0]               idx2;

  // Only the low register bits of the core's rd addresses carry meaning.
  if (AW > REG_AW) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^{ret_rd_addr[AW-1:REG_AW], wrd_add1[AW-1:REG_AW],
                              wrd_add2[AW-1:REG_AW]};
  end

  assign rd_valid = ret_rd_en & (ret_rd_addr[REG_AW-1:0] != '0);
  assign qual     = ret_vld & (rd_valid | (ret_mem_wen != 3'b000));
  assign full     = (count == FULL_CNT);
  // A pop in the same cycle never frees a slot for a push into a full buffer.
  assign push     = qual & ~full;
  assign ret_rdy  = ~full;
  assign out_vld  = (count != '0) & ~pend[rd_ptr];
  assign out_rec  = entries[rd_ptr];
  assign pop      = out_vld & out_rdy;
  assign new_pend = ret_rd_pend & rd_valid;

  assign wb1_en   = wrd_en1 & (wrd_add1[REG_AW-1:0] != '0);
  assign wb2_en   = wrd_en2 & (wrd_add2[REG_AW-1:0] != '0);

  // Normalise the incoming retire event into a record.
  always_comb begin
    new_rec           = '0;
    new_rec.pc        = ret_pc;
    new_rec.mem_wen   = ret_mem_wen;
    new_rec.mem_wdata = mask_store_data(ret_mem_wen, ret_mem_wdata);
    if (rd_valid) begin
      new_rec.rd_addr  = ret_rd_addr[REG_AW-1:0];
      new_rec.rd_wdata = ret_rd_pend ? 32'd0 : ret_rd_wdata;
    end
    if (ret_mem_ren != 3'b000) new_rec.mem_raddr = ret_mem_raddr;
    if (ret_mem_wen != 3'b000) new_rec.mem_waddr = ret_mem_waddr;
  end

  // Flatten the stored rd addresses for the two search units.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rd_addrs[i] = entries[i].rd_addr;
    end
  end

  trace_pend_match #(.DEPTH(DEPTH)) u_match1 (
    .en       (wb1_en),
    .addr     (wrd_add1[REG_AW-1:0]),
    .pend     (pend),
    .rd_addrs (rd_addrs),
    .head     (rd_ptr),
    .excl_en  (1'b0),
    .excl_idx ('0),
    .hit      (hit1),
    .idx      (idx1)
  );

  // Port 2 skips whatever port 1 claimed so the pair resolves the two oldest.
  trace_pend_match #(.DEPTH(DEPTH)) u_match2 (
    .en       (wb2_en),
    .addr     (wrd_add2[REG_AW-1:0]),
    .pend     (pend),
    .rd_addrs (rd_addrs),
    .head     (rd_ptr),
    .excl_en  (hit1),
    .excl_idx (idx1),
    .hit      (hit2),
    .idx      (idx2)
  );

  // Pointers, occupancy, pop counter and sticky error flags.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      retired_cnt_o <= '0;
      ovf_o         <= 1'b0;
      orphan_o      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr        <= rd_ptr + 1'b1;
        retired_cnt_o <= retired_cnt_o + 32'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (qual && full) ovf_o <= 1'b1;
      if ((wb1_en && !hit1) || (wb2_en && !hit2)) orphan_o <= 1'b1;
    end
  end

  // Record storage: new entries at the tail, late rd values patched in place.
  // Pushes land in an empty slot (pend=0), so they never collide with a match.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
      pend <= '0;
    end else begin
      if (push) begin
        entries[wr_ptr] <= new_rec;
        pend[wr_ptr]    <= new_pend;
      end
      if (hit1) begin
        entries[idx1].rd_wdata <= wrd_data1;
        pend[idx1]             <= 1'b0;
      end
      if (hit2) begin
        entries[idx2].rd_wdata <= wrd_data2;
        pend[idx2]             <= 1'b0;
      end
    end
  end

endmodule
